// File: rtl/corr_scan_ctrl.sv
// corr_scan_ctrl: round-robin service scheduler for NCH correlator channels
// sharing one register bus. Pending channels are read out (Cnt/Low/High),
// their Status is cleared, and results are queued in a small FIFO. Host
// accesses are slotted in between service sequences.
module corr_scan_ctrl #(
    parameter int          NCH        = 4,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] A_CNT      = 16'h0740,
    parameter logic [15:0] A_LOW      = 16'h0744,
    parameter logic [15:0] A_HIGH     = 16'h0748,
    parameter logic [15:0] A_STS      = 16'h074c,
    localparam int         CHW        = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scan_en,
    input  logic [NCH-1:0]  cseen,
    output logic [NCH-1:0]  ch_en,
    output logic [31:0]     bus_addr,
    output logic [31:0]     bus_wdata,
    output logic            bus_write,
    output logic            bus_read,
    input  logic [31:0]     bus_rdata,
    input  logic            host_req,
    input  logic [CHW-1:0]  host_ch,
    input  logic [31:0]     host_addr,
    input  logic [31:0]     host_wdata,
    input  logic            host_wr,
    output logic            host_gnt,
    output logic [31:0]     host_rdata,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [CHW-1:0]  res_chan,
    output logic [31:0]     res_cnt,
    output logic [63:0]     res_corr,
    output logic            busy
);
    localparam int             AW    = $clog2(FIFO_DEPTH);
    localparam int             LASTI = NCH - 1;
    localparam logic [CHW-1:0] LAST  = LASTI[CHW-1:0];
    localparam logic [NCH-1:0] ONE   = {{(NCH-1){1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HOST = 3'd1;
    localparam logic [2:0] S_CNT  = 3'd2;
    localparam logic [2:0] S_LOW  = 3'd3;
    localparam logic [2:0] S_HIGH = 3'd4;
    localparam logic [2:0] S_CLR  = 3'd5;

    typedef struct packed {
        logic [CHW-1:0] chan;
        logic [31:0]    cnt;
        logic [63:0]    corr;
    } ent_t;

    logic [2:0]     state, state_nxt;
    logic [CHW-1:0] rr_ptr, chan, winner, idx;
    logic           win_vld;
    logic [CHW-1:0] hold_ch;
    logic [1:0]     hold_cnt;
    logic [NCH-1:0] holdoff, elig;
    logic [31:0]    cnt_r, low_r, high_r;
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           fifo_full, push, pop;
    ent_t           fifo_mem [FIFO_DEPTH];

    // A just-serviced channel is masked briefly so its cseen can fall after the Status clear
    assign holdoff = (hold_cnt != 2'd0) ? (ONE << hold_ch) : '0;
    assign elig    = cseen & ~holdoff;
    assign busy    = (state != S_IDLE);

    // Round-robin pick: first eligible channel at or after rr_ptr, wrapping at NCH
    always_comb begin
        winner  = '0;
        win_vld = 1'b0;
        idx     = rr_ptr;
        for (int i = 0; i < NCH; i++) begin
            if (!win_vld && elig[idx]) begin
                winner  = idx;
                win_vld = 1'b1;
            end
            idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    // Next state: host has priority in IDLE; a sequence only starts if its result has room
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: begin
                if (host_req)                              state_nxt = S_HOST;
                else if (scan_en && win_vld && !fifo_full) state_nxt = S_CNT;
            end
            S_CNT:   state_nxt = S_LOW;
            S_LOW:   state_nxt = S_HIGH;
            S_HIGH:  state_nxt = S_CLR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus drive decoded from state; everything idles low outside an access
    always_comb begin
        ch_en     = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_write = 1'b0;
        bus_read  = 1'b0;
        host_gnt  = 1'b0;
        case (state)
            S_HOST: begin
                ch_en     = ONE << host_ch;
                bus_addr  = host_addr;
                bus_wdata = host_wr ? host_wdata : '0;
                bus_write = host_wr;
                bus_read  = ~host_wr;
                host_gnt  = 1'b1;
            end
            S_CNT:  begin ch_en = ONE << chan; bus_addr = {16'h0, A_CNT};  bus_read  = 1'b1; end
            S_LOW:  begin ch_en = ONE << chan; bus_addr = {16'h0, A_LOW};  bus_read  = 1'b1; end
            S_HIGH: begin ch_en = ONE << chan; bus_addr = {16'h0, A_HIGH}; bus_read  = 1'b1; end
            S_CLR:  begin ch_en = ONE << chan; bus_addr = {16'h0, A_STS};  bus_write = 1'b1; end
            default: ;
        endcase
    end

    // FSM, winner latch, result capture, rr advance and holdoff countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            chan       <= '0;
            rr_ptr     <= '0;
            hold_ch    <= '0;
            hold_cnt   <= 2'd0;
            cnt_r      <= '0;
            low_r      <= '0;
            high_r     <= '0;
            host_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && state_nxt == S_CNT) chan <= winner;
            if (state == S_CNT)  cnt_r  <= bus_rdata;
            if (state == S_LOW)  low_r  <= bus_rdata;
            if (state == S_HIGH) high_r <= bus_rdata;
            if (state == S_HOST && !host_wr) host_rdata <= bus_rdata;
            if (state == S_CLR) begin
                rr_ptr   <= (chan == LAST) ? '0 : chan + 1'b1;
                hold_ch  <= chan;
                hold_cnt <= 2'd2;
            end else if (hold_cnt != 2'd0) begin
                hold_cnt <= hold_cnt - 2'd1;
            end
        end
    end

    assign push      = (state == S_CLR);
    assign pop       = res_valid && res_ready;
    assign res_valid = (wr_ptr != rd_ptr);
    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign res_chan  = fifo_mem[rd_ptr[AW-1:0]].chan;
    assign res_cnt   = fifo_mem[rd_ptr[AW-1:0]].cnt;
    assign res_corr  = fifo_mem[rd_ptr[AW-1:0]].corr;

    // Result FIFO; push lands at the end of the Status-clear cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[AW-1:0]] <= '{chan: chan, cnt: cnt_r, corr: {high_r, low_r}};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_corr_scan_ctrl.sv
// tb_corr_scan_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-plan model of the scheduler.
module tb_corr_scan_ctrl;
    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst, scan_en, res_ready, host_req, host_wr;
    logic [3:0]  cseen, ch_en;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, host_addr, host_wdata, host_rdata, res_cnt;
    logic        bus_write, bus_read, host_gnt, res_valid, busy;
    logic [1:0]  host_ch, res_chan;
    logic [63:0] res_corr;

    corr_scan_ctrl dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .cseen(cseen), .ch_en(ch_en),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write), .bus_read(bus_read),
        .bus_rdata(bus_rdata), .host_req(host_req), .host_ch(host_ch), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_wr(host_wr), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan), .res_cnt(res_cnt),
        .res_corr(res_corr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- channel register model ----------------
    logic [31:0] ch_cnt [NCH];
    logic [31:0] ch_low [NCH];
    logic [31:0] ch_high[NCH];

    function automatic logic [31:0] rdv(input int c, input logic [31:0] a);
        case (a)
            32'h0740: return ch_cnt[c];
            32'h0744: return ch_low[c];
            32'h0748: return ch_high[c];
            default:  return {a[15:0], 12'hA50, 4'(c)};
        endcase
    endfunction

    always_comb begin
        bus_rdata = '0;
        for (int c = 0; c < NCH; c++) if (ch_en[c]) bus_rdata = rdv(c, bus_addr);
    end

    // ---------------- behavioural model: plan of expected bus cycles ----------------
    typedef struct { logic [1:0] chan; logic [31:0] cnt; logic [63:0] corr; } res_t;
    typedef struct {
        logic [3:0] en; logic [31:0] addr, wdata;
        logic rd, wr, gnt, chk_wd, push, host_rd; int ch; res_t res;
    } op_t;

    op_t  plan[$];
    res_t fq[$];
    int   rr = 0;
    int   hold_until[NCH];
    int   cyc = 0;
    logic hrd_pend = 1'b0;
    logic [31:0] hrd_exp;

    function automatic op_t mk(input int ch, input logic [31:0] addr, input logic [31:0] wd,
                               input logic rd, input logic wr, input logic gnt, input logic cw);
        op_t o;
        o.en = 4'b0001 << ch; o.addr = addr; o.wdata = wd; o.rd = rd; o.wr = wr; o.gnt = gnt;
        o.chk_wd = cw; o.push = 1'b0; o.host_rd = 1'b0; o.ch = ch;
        o.res.chan = 2'(ch); o.res.cnt = '0; o.res.corr = '0;
        return o;
    endfunction

    always @(negedge clk) begin
        op_t o;
        int  w;
        logic popn, pushn;
        cyc++;
        if (rst) begin
            plan.delete(); fq.delete(); rr = 0; hrd_pend = 1'b0;
            for (int c = 0; c < NCH; c++) hold_until[c] = 0;
            chk("rst_ch_en", ch_en, 0);
            chk("rst_strobes", {bus_read, bus_write, host_gnt}, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
        end else begin
            if (hrd_pend) chk("host_rdata", host_rdata, hrd_exp);
            hrd_pend = 1'b0;
            chk("res_valid", res_valid, fq.size() != 0);
            if (fq.size() != 0) begin
                chk("res_chan", res_chan, fq[0].chan);
                chk("res_cnt",  res_cnt,  fq[0].cnt);
                chk("res_corr", res_corr, fq[0].corr);
            end
            popn  = (fq.size() != 0) && res_ready;
            pushn = 1'b0;
            if (plan.size() == 0) begin
                chk("idle_bus", {ch_en, bus_read, bus_write, host_gnt, busy}, 0);
                if (host_req) begin
                    o = mk(int'(host_ch), host_addr, host_wdata, !host_wr, host_wr, 1'b1, host_wr);
                    o.host_rd = !host_wr;
                    plan.push_back(o);
                end else if (scan_en && fq.size() < 4) begin
                    w = -1;
                    for (int i = 0; i < NCH; i++) begin
                        int c;
                        c = (rr + i) % NCH;
                        if (w < 0 && cseen[c] && cyc >= hold_until[c]) w = c;
                    end
                    if (w >= 0) begin
                        plan.push_back(mk(w, 32'h0740, 0, 1'b1, 1'b0, 1'b0, 1'b0));
                        plan.push_back(mk(w, 32'h0744, 0, 1'b1, 1'b0, 1'b0, 1'b0));
                        plan.push_back(mk(w, 32'h0748, 0, 1'b1, 1'b0, 1'b0, 1'b0));
                        o = mk(w, 32'h074c, 0, 1'b0, 1'b1, 1'b0, 1'b1);
                        o.push = 1'b1; o.res.cnt = ch_cnt[w]; o.res.corr = {ch_high[w], ch_low[w]};
                        plan.push_back(o);
                    end
                end
            end else begin
                o = plan.pop_front();
                chk("busy",    busy,     1);
                chk("ch_en",   ch_en,    o.en);
                chk("addr",    bus_addr, o.addr);
                chk("strobes", {bus_read, bus_write, host_gnt}, {o.rd, o.wr, o.gnt});
                if (o.chk_wd) chk("wdata", bus_wdata, o.wdata);
                if (o.host_rd) begin hrd_pend = 1'b1; hrd_exp = rdv(o.ch, o.addr); end
                pushn = o.push;
            end
            if (popn) void'(fq.pop_front());
            if (pushn) begin
                fq.push_back(o.res);
                rr = (o.ch + 1) % NCH;
                hold_until[o.ch] = cyc + 3;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] clr_seen = '0, keep = '0;
    logic       gnt_seen = 1'b0, rnd_data = 1'b0;
    int         hw = 0;

    always @(negedge clk) begin
        clr_seen = (bus_write && bus_addr == 32'h074c) ? ch_en : 4'b0;
        gnt_seen = host_gnt;
    end

    // One cycle: channels drop cseen after a Status clear, host drops req after its grant
    task automatic step();
        @(posedge clk); #1;
        for (int c = 0; c < NCH; c++) if (clr_seen[c]) begin
            if (!keep[c]) cseen[c] = 1'b0;
            if (rnd_data) begin ch_cnt[c] = $urandom; ch_low[c] = $urandom; ch_high[c] = $urandom; end
        end
        if (host_req) begin
            if (gnt_seen) host_req = 1'b0;
            else begin
                hw++;
                if (hw > 40) begin chk("host_wait_bound", hw, 0); host_req = 1'b0; end
            end
        end
    endtask

    initial begin
        int nr, nw;
        logic [31:0] ea [4];
        ea[0] = 32'h0740; ea[1] = 32'h0744; ea[2] = 32'h0748; ea[3] = 32'h074c;
        rst = 1'b1; scan_en = 1'b0; cseen = '0; res_ready = 1'b1; host_req = 1'b0;
        host_ch = '0; host_addr = '0; host_wdata = '0; host_wr = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            ch_cnt[c] = 32'h10 * c + 32'h11; ch_low[c] = 32'h100 + c; ch_high[c] = 32'h200 + c;
        end
        ch_cnt[2] = 32'h64; ch_low[2] = 32'hFFFF_FFF0; ch_high[2] = 32'hFFFF_FFFF;
        repeat (3) step();
        rst = 1'b0; scan_en = 1'b1;

        // 1: idle with no pending channels
        repeat (20) step();
        @(negedge clk);
        chk("t1_busy", busy, 0);
        chk("t1_valid", res_valid, 0);

        // 2: single ch2 service, literal bus sequence and signed result
        step(); cseen = 4'b0100;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            step(); @(negedge clk);
            chk("t2_addr", bus_addr, ea[k]);
            chk("t2_en", ch_en, 4'b0100);
            chk("t2_rw", {bus_read, bus_write}, (k < 3) ? 2'b10 : 2'b01);
        end
        step(); @(negedge clk);
        chk("t2_valid", res_valid, 1);
        chk("t2_chan", res_chan, 2);
        chk("t2_cnt", res_cnt, 100);
        chk("t2_corr", res_corr, -64'sd16);

        // 3: rr from reset, ch0 then ch3 queued in order
        step(); rst = 1'b1; step(); step(); rst = 1'b0;
        res_ready = 1'b0; cseen = 4'b1001;
        repeat (12) step();
        @(negedge clk);
        chk("t3_head0", {res_valid, res_chan, res_cnt}, {1'b1, 2'd0, 32'h11});
        step(); res_ready = 1'b1; step(); res_ready = 1'b0;
        @(negedge clk);
        chk("t3_head1", {res_valid, res_chan, res_cnt}, {1'b1, 2'd3, 32'h41});
        step(); res_ready = 1'b1; step(); res_ready = 1'b0;
        @(negedge clk);
        chk("t3_empty", res_valid, 0);

        // 4: fill FIFO from a held ch1, stall while full, one pop admits one sequence
        keep = 4'b0010; cseen = 4'b0010;
        repeat (40) step();
        nr = 0;
        repeat (10) begin step(); @(negedge clk); nr += int'(bus_read) + int'(bus_write); end
        chk("t4_full_quiet", nr, 0);
        chk("t4_valid", res_valid, 1);
        step(); res_ready = 1'b1; step(); res_ready = 1'b0;
        nr = 0; nw = 0;
        repeat (20) begin step(); @(negedge clk); nr += int'(bus_read); nw += int'(bus_write); end
        chk("t4_one_seq", {nr[7:0], nw[7:0]}, {8'd3, 8'd1});
        keep = '0; res_ready = 1'b1;
        repeat (30) step();

        // 5: host read arriving during RD_LOW waits for the sequence
        step(); cseen = 4'b0001;
        step(); step();
        host_req = 1'b1; host_ch = 2'd1; host_addr = 32'h0544; host_wr = 1'b0; hw = 0;
        repeat (3) step(); @(negedge clk);
        chk("t5_wait", {host_gnt, busy}, 2'b00);
        step(); @(negedge clk);
        chk("t5_gnt", {host_gnt, ch_en, bus_read}, {1'b1, 4'b0010, 1'b1});
        step(); @(negedge clk);
        chk("t5_rdata", host_rdata, 32'h0544_A501);

        // 6: reset during RD_HIGH aborts; sequence repeats after release
        repeat (5) step();
        step(); cseen = 4'b0010;
        step(); step(); step();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_abort", {ch_en, bus_read, bus_write, res_valid}, 0);
        step(); step(); rst = 1'b0;
        nr = 0; nw = 0;
        repeat (8) begin @(negedge clk); nr += int'(bus_read); nw += int'(bus_write); step(); end
        chk("t6_repeat", {nr[7:0], nw[7:0]}, {8'd3, 8'd1});
        repeat (5) step();

        // Random traffic
        rnd_data = 1'b1;
        repeat (2500) begin
            step();
            scan_en   = ($urandom_range(9) != 0);
            res_ready = ($urandom_range(99) < 60);
            for (int c = 0; c < NCH; c++) begin
                if (!cseen[c] && $urandom_range(99) < 8) cseen[c] = 1'b1;
                keep[c] = ($urandom_range(3) == 0);
            end
            if (!host_req && $urandom_range(99) < 4) begin
                host_req = 1'b1; host_ch = 2'($urandom_range(3)); host_wr = 1'($urandom_range(1));
                host_addr = ($urandom_range(1) != 0) ? 32'h0740 + 4 * $urandom_range(2) : {16'h0, 16'($urandom)};
                host_wdata = $urandom; hw = 0;
            end
        end
        keep = '0; cseen = '0; res_ready = 1'b1;
        repeat (30) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
